// File: rtl/c2f_reader.sv
// Reads each committed C2F chunk out of RAM as a 64-bit ready/valid stream and pulses dtAck_out once the last QW is taken.
// First beat lands 3 cycles after wrPtr_in != rdPtr_in; a credit-gated 2-entry buffer absorbs ready_in stalls without dropping data.
module c2f_reader #(
  parameter int CHUNK_QW_NBITS   = 7,
  parameter int NUM_CHUNKS_NBITS = 2
) (
  input  logic                                     clk_in,
  input  logic                                     reset_in,
  input  logic [NUM_CHUNKS_NBITS-1:0]              wrPtr_in,
  input  logic [NUM_CHUNKS_NBITS-1:0]              rdPtr_in,
  output logic                                     dtAck_out,
  output logic [NUM_CHUNKS_NBITS+CHUNK_QW_NBITS-1:0] ramAddr_out,
  input  logic [63:0]                              ramData_in,
  output logic [63:0]                              data_out,
  output logic                                     valid_out,
  input  logic                                     ready_in,
  output logic                                     eop_out
);

  localparam logic [CHUNK_QW_NBITS-1:0] OFF_ONE = 1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, ACK, WAIT} state_t;

  state_t                      state;
  logic [NUM_CHUNKS_NBITS-1:0] chunk;
  logic [CHUNK_QW_NBITS-1:0]   offset;
  logic                        inFlight;
  logic                        inFlightEop;
  logic [63:0]                 bufData0, bufData1;
  logic                        bufEop0, bufEop1;
  logic [1:0]                  bufCount;

  logic pop, push, issue, lastOffset, creditOk;

  assign valid_out   = (bufCount != 2'd0);
  assign data_out    = bufData0;
  assign eop_out     = valid_out & bufEop0;
  assign ramAddr_out = {chunk, offset};

  assign pop        = valid_out & ready_in;
  assign push       = inFlight;
  assign lastOffset = &offset;
  // A read only issues if its data is sure to find a free slot when it lands next cycle.
  assign creditOk   = ({1'b0, bufCount} + {2'b00, inFlight}) < (3'd2 + {2'b00, pop});
  assign issue      = (state == READ) && creditOk;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= IDLE;
      chunk       <= '0;
      offset      <= '0;
      inFlight    <= 1'b0;
      inFlightEop <= 1'b0;
      dtAck_out   <= 1'b0;
      bufData0    <= '0;
      bufData1    <= '0;
      bufEop0     <= 1'b0;
      bufEop1     <= 1'b0;
      bufCount    <= 2'd0;
    end else begin
      inFlight  <= issue;
      dtAck_out <= 1'b0;
      if (issue) inFlightEop <= lastOffset;

      case (state)
        IDLE: begin
          if (wrPtr_in != rdPtr_in) begin
            chunk  <= rdPtr_in;
            offset <= '0;
            state  <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (lastOffset) state <= DRAIN;
            else            offset <= offset + OFF_ONE;
          end
        end
        DRAIN: begin
          if (!inFlight && (bufCount == {1'b0, pop})) begin
            state     <= ACK;
            dtAck_out <= 1'b1;
          end
        end
        ACK:  state <= WAIT;
        // Hold off until tlp_xcvr has registered the ack, so the chunk is never re-read.
        WAIT: if (rdPtr_in != chunk) state <= IDLE;
        default: state <= IDLE;
      endcase

      case ({push, pop})
        2'b10: begin
          if (bufCount == 2'd0) begin
            bufData0 <= ramData_in;
            bufEop0  <= inFlightEop;
          end else begin
            bufData1 <= ramData_in;
            bufEop1  <= inFlightEop;
          end
          bufCount <= bufCount + 2'd1;
        end
        2'b01: begin
          bufData0 <= bufData1;
          bufEop0  <= bufEop1;
          bufCount <= bufCount - 2'd1;
        end
        2'b11: begin
          if (bufCount == 2'd1) begin
            bufData0 <= ramData_in;
            bufEop0  <= inFlightEop;
          end else begin
            bufData0 <= bufData1;
            bufEop0  <= bufEop1;
            bufData1 <= ramData_in;
            bufEop1  <= inFlightEop;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c2f_reader.sv
// Bench for c2f_reader: RAM and tlp_xcvr pointer models, a queue scoreboard of committed chunks,
// a table of streaming scenarios plus hand-written latency and mid-chunk reset sequences.
module tb_c2f_reader;
  localparam int QW = 128;

  typedef struct packed { logic [63:0] d; logic e; } beat_t;
  typedef struct { int nChunks; int readyMode; int ackDelay; int expBeats; int expAcks; } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wrPtr = '0;
  logic [1:0]  rdPtr = '0;
  logic        ready = 1'b0;
  logic [63:0] ramData = '0;
  logic        dtAck, valid, eop;
  logic [8:0]  ramAddr;
  logic [63:0] data;
  logic [63:0] ram [4*QW];

  int cyc = 0;
  int nCmp = 0;
  int nFail = 0;

  beat_t      expQ[$];
  logic [1:0] ackChunks[$];
  int beats = 0, acks = 0, dataErr = 0, stallErr = 0, ackTimeErr = 0, lastEopCyc = -10;
  int ackDelay = 0, pend = -1, resumeAt = -1, waitErr = 0, resumeErr = 0, resumeChk = 0;
  logic        prevStall = 1'b0;
  logic [63:0] prevData = '0;
  logic [8:0]  heldAddr = '0;

  c2f_reader #(.CHUNK_QW_NBITS(7), .NUM_CHUNKS_NBITS(2)) dut (
    .clk_in(clk), .reset_in(rst), .wrPtr_in(wrPtr), .rdPtr_in(rdPtr),
    .dtAck_out(dtAck), .ramAddr_out(ramAddr), .ramData_in(ramData),
    .data_out(data), .valid_out(valid), .ready_in(ready), .eop_out(eop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ramData <= ram[ramAddr];

  // Stream monitor: every accepted beat must be the next QW of the committed chunks.
  always @(negedge clk) begin : mon
    beat_t b;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall && (!valid || data !== prevData)) stallErr++;
      if (!valid && eop) dataErr++;
      if (valid && ready) begin
        beats++;
        if (expQ.size() == 0) dataErr++;
        else begin
          b = expQ.pop_front();
          if (data !== b.d || eop !== b.e) dataErr++;
        end
        if (eop) lastEopCyc = cyc;
      end
      if (dtAck) begin
        acks++;
        ackChunks.push_back(ramAddr[8:7]);
        if (cyc != lastEopCyc + 1) ackTimeErr++;
      end
      prevStall = valid && !ready;
      prevData  = data;
    end
  end

  // tlp_xcvr model: advances rdPtr ackDelay cycles after each ack.
  always @(posedge clk) begin : ptrModel
    #1;
    if (rst) begin
      pend = -1;
      resumeAt = -1;
    end else begin
      if (resumeAt >= 0) begin
        if (cyc == resumeAt - 1 && ramAddr !== heldAddr) resumeErr++;
        if (cyc == resumeAt) begin
          resumeChk++;
          if (ramAddr !== {rdPtr, 7'd0}) resumeErr++;
          resumeAt = -1;
        end
      end
      if (dtAck) begin
        heldAddr = ramAddr;
        pend = ackDelay;
      end
      if (pend == 0) begin
        rdPtr = rdPtr + 2'd1;
        pend = -1;
        if (ackDelay > 0 && wrPtr != rdPtr) resumeAt = cyc + 2;
      end else if (pend > 0) begin
        if (ramAddr !== heldAddr) waitErr++;
        pend--;
      end
    end
  end

  function automatic logic [63:0] seq64(input int i);
    return {32'hC2F0_0000 + i[31:0], ~i[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, " dtAck"}, dtAck, 0);
    check({tag, " valid"}, valid, 0);
    check({tag, " eop"}, eop, 0);
    check({tag, " ramAddr"}, ramAddr, 0);
    check({tag, " data"}, data, 0);
  endtask

  task automatic clearCounters();
    beats = 0; acks = 0; dataErr = 0; stallErr = 0; ackTimeErr = 0;
    waitErr = 0; resumeErr = 0; resumeChk = 0;
    ackChunks.delete();
  endtask

  // CPU side: fill the chunk at wrPtr, record it in the scoreboard, then commit it.
  task automatic commitChunk(input bit useSeq);
    for (int i = 0; i < QW; i++) begin
      logic [63:0] w;
      w = useSeq ? seq64(i) : {$urandom, $urandom};
      ram[{wrPtr, 7'(i)}] = w;
      expQ.push_back('{w, (i == QW - 1)});
    end
    wrPtr = wrPtr + 2'd1;
  endtask

  task automatic waitAcks(input int n);
    int budget;
    budget = 5000;
    while (acks < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic runVec(input int idx, input vec_t v);
    int committed;
    int budget;
    logic [1:0] start;
    logic [1:0] occ;
    committed = 0;
    budget = 20000;
    start = rdPtr;
    clearCounters();
    ackDelay = v.ackDelay;
    while (acks < v.nChunks && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      case (v.readyMode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 0);
        default: ready = ($urandom_range(0, 1) == 1);
      endcase
      occ = wrPtr - rdPtr;
      if (committed < v.nChunks && occ != 2'd3 &&
          (v.readyMode != 2 || $urandom_range(0, 7) == 0)) begin
        commitChunk(1'b0);
        committed++;
      end
    end
    ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check($sformatf("vec%0d beats", idx), beats, v.expBeats);
    check($sformatf("vec%0d acks", idx), acks, v.expAcks);
    check($sformatf("vec%0d data errors", idx), dataErr, 0);
    check($sformatf("vec%0d stall errors", idx), stallErr, 0);
    check($sformatf("vec%0d ack timing errors", idx), ackTimeErr, 0);
    check($sformatf("vec%0d reads during wait", idx), waitErr, 0);
    check($sformatf("vec%0d leftover beats", idx), expQ.size(), 0);
    for (int k = 0; k < v.nChunks && k < ackChunks.size(); k++) begin
      logic [1:0] e;
      e = start + 2'(k);
      check($sformatf("vec%0d ack chunk %0d", idx, k), ackChunks[k], e);
    end
    if (v.ackDelay > 0) begin
      check($sformatf("vec%0d resume checks", idx), resumeChk, 1);
      check($sformatf("vec%0d resume errors", idx), resumeErr, 0);
    end
  endtask

  task automatic singleChunk();
    logic [1:0] start;
    start = rdPtr;
    clearCounters();
    ackDelay = 0;
    ready = 1'b1;
    @(posedge clk); #1;
    commitChunk(1'b1);
    @(posedge clk); #1;
    check("lat c1 valid", valid, 0);
    check("lat c1 addr", ramAddr, {start, 7'd0});
    @(posedge clk); #1;
    check("lat c2 valid", valid, 0);
    @(posedge clk); #1;
    check("lat c3 valid", valid, 1);
    check("lat c3 data", data, seq64(0));
    waitAcks(1);
    check("single beats", beats, QW);
    check("single acks", acks, 1);
    check("single data errors", dataErr, 0);
    check("single ack timing errors", ackTimeErr, 0);
    check("single rdPtr", rdPtr, start + 2'd1);
  endtask

  task automatic midReset();
    logic [1:0] start;
    int budget;
    int preBeats;
    start = rdPtr;
    clearCounters();
    ready = 1'b1;
    commitChunk(1'b1);
    budget = 2000;
    while (beats < 41 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("mid reached beat 40", (beats >= 41), 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutputsZero("mid reset");
    preBeats = beats;
    expQ.delete();
    for (int i = 0; i < QW; i++) expQ.push_back('{ram[{rdPtr, 7'(i)}], (i == QW - 1)});
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid c2 valid", valid, 0);
    @(posedge clk); #1;
    check("mid c3 valid", valid, 1);
    check("mid restart data", data, seq64(0));
    waitAcks(1);
    check("mid beats after reset", beats - preBeats, QW);
    check("mid acks", acks, 1);
    check("mid data errors", dataErr, 0);
    check("mid leftover beats", expQ.size(), 0);
    check("mid rdPtr", rdPtr, start + 2'd1);
  endtask

  initial begin : main
    vec_t vecs[4];
    vecs[0] = '{5, 0, 0, 5 * QW, 5};
    vecs[1] = '{2, 1, 0, 2 * QW, 2};
    vecs[2] = '{3, 2, 0, 3 * QW, 3};
    vecs[3] = '{2, 0, 10, 2 * QW, 2};
    for (int i = 0; i < 4 * QW; i++) ram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutputsZero("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) runVec(i, vecs[i]);
    singleChunk();
    midReset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/c2f_reader.md
# c2f_reader

Consumer for the CPU→FPGA burst pipe. The CPU burst-writes whole chunks into the C2F RAM via `tlp_xcvr` and then advances `c2fWrPtr`. This block detects committed chunks and reads each one out of the RAM in order as a ready/valid 64-bit stream. Once the last QW of a chunk has been accepted downstream, it pulses `c2fDTAck` so that `tlp_xcvr` advances `c2fRdPtr` and releases the chunk back to the CPU.

## Interface
- `CHUNK_QW_NBITS`, default 7: log2 of QWs per chunk (default 128 QW = 1 KiB).
- `NUM_CHUNKS_NBITS`, default 2: log2 of chunks in the ring (default 4).
- `clk_in` input 1: system clock; all logic is on the rising edge.
- `reset_in` input 1: asynchronous, active-high reset.
- `wrPtr_in` input NUM_CHUNKS_NBITS: CPU write pointer (`c2fWrPtr` from `tlp_xcvr`).
- `rdPtr_in` input NUM_CHUNKS_NBITS: read pointer (`c2fRdPtr` from `tlp_xcvr`).
- `dtAck_out` output 1: one-cycle pulse meaning the chunk is consumed (drives `c2fDTAck`).
- `ramAddr_out` output NUM_CHUNKS_NBITS+CHUNK_QW_NBITS: RAM read address `{chunk, offset}`.
- `ramData_in` input 64: RAM read data, valid one cycle after the address is presented.
- `data_out` output 64: stream data.
- `valid_out` output 1: stream valid.
- `ready_in` input 1: stream ready; a beat transfers when `valid_out && ready_in`.
- `eop_out` output 1: qualifies the last QW of a chunk; valid only while `valid_out` is high.

## Operation
- State machine: IDLE, READ, DRAIN, ACK, WAIT.
- **IDLE**
  - When `wrPtr_in != rdPtr_in`, latch `chunk <= rdPtr_in`, clear the issue offset and go to READ.
  - When `wrPtr_in == rdPtr_in`, the ring is empty and the block stays in IDLE.
- **READ**
  - Issue one RAM read per cycle at `{chunk, offset}` when the credit rule allows.
  - Credit rule: `bufCount + inFlight - pop < 2`, where:
    - `bufCount` is the 2-entry output buffer occupancy (0..2);
    - `inFlight` is 1 if a read was issued in the previous cycle;
    - `pop` is 1 if `valid_out && ready_in` this cycle.
  - On each issue, `offset` increments.
  - After issuing offset 2^CHUNK_QW_NBITS−1, go to DRAIN.
- **DRAIN**: wait until the last QW has been accepted downstream (buffer empty, nothing in flight), then go to ACK.
- **ACK**: `dtAck_out = 1` for exactly one cycle, then go to WAIT.
- **WAIT**: stay until `rdPtr_in != chunk`, then return to IDLE. This guarantees a chunk is never re-read while `tlp_xcvr` has not yet registered the ack.
- **Output buffer**: 2-entry FIFO written with `ramData_in` in the cycle after each issue.
  - `data_out` and `eop_out` come from the head entry; `valid_out = (bufCount != 0)`.
  - `eop_out` is tagged on the entry whose issue offset was all-ones.
- **Pointer arithmetic**: chunk indices are NUM_CHUNKS_NBITS wide and wrap modulo 2^NUM_CHUNKS_NBITS (3→0 at default). The block never computes occupancy; it relies only on the `!=` test.
- **Ring-full check**: the block does not check for a full ring; that is the CPU's responsibility.
- **Byte masks**: ignored. Whole QWs are streamed even if the CPU wrote partial DWs.
- **Simultaneous push and pop** with the buffer full is legal and leaves the count unchanged. The credit rule guarantees the buffer never overflows.
- **Reset behaviour**
  - Reset (including mid-chunk) forces IDLE, empties the buffer and drops in-flight reads.
  - After release, a partially streamed chunk restarts from offset 0 if `wrPtr_in != rdPtr_in`. Downstream must tolerate the repeat.

## Timing
- Reset values: `dtAck_out=0`, `valid_out=0`, `eop_out=0`, `ramAddr_out=0`, `data_out=0`. State is IDLE, offset 0, `bufCount` 0, `inFlight` 0.
- Cycle 0: IDLE with `wrPtr_in != rdPtr_in`.
- Cycle 1: READ, `ramAddr_out={chunk,0}`.
- Cycle 2: `ramData_in` valid and written into the buffer.
- Cycle 3: first `valid_out=1`.
- Throughput is one QW per cycle while `ready_in` is held high. A 128-QW chunk streams on cycles 3..130.
- Last QW accepted in cycle N (buffer now empty): DRAIN exits at the end of cycle N, ACK is in cycle N+1, and `dtAck_out` is high only in cycle N+1. WAIT starts in cycle N+2.
- Back-to-back chunks: earliest next READ is 2 cycles after `rdPtr_in` changes (WAIT→IDLE, then IDLE→READ).
- `ramAddr_out` holds its last value when not issuing. The RAM read is side-effect-free.

## Test plan
- **Reset:** assert `reset_in` asynchronously mid-cycle with `wrPtr_in=1`, `rdPtr_in=0` → all outputs 0 immediately. After release, first `valid_out` 3 cycles later.
- **Single chunk, full rate:** preload RAM chunk 0 with SEQ64[0..127], `wrPtr 0→1`, `ready_in=1`.
  - 128 consecutive valid beats matching SEQ64, `eop_out` only on beat 127.
  - One `dtAck_out` pulse; the model increments `rdPtr` and the block returns to IDLE.
- **Backpressure:** `ready_in` driven by a 1-in-3 pattern, then random → identical data sequence with no drop or duplication. `bufCount` never exceeds 2; `data_out` is stable while stalled.
- **Wrap-around:** 4 chunks, `wrPtr` stepped 1,2,3,0,1 → chunks read in order 0,1,2,3,0. Address high bits go 3→0. Exactly 5 acks.
- **Delayed pointer:** model updates `rdPtr_in` 10 cycles after `dtAck_out` → the block stays in WAIT and issues no RAM reads. Then reading resumes 2 cycles after the update.
- **Mid-chunk reset:** reset after beat 40 of chunk 0 → `valid_out` drops immediately with no ack. After release, the chunk re-streams from SEQ64[0].
